// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester handshakes and register-file write-port signals shared by
// regfile_wb_arbiter (slave side) and the writeback requesters (master side).
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              req2_valid;
    logic [ADDR_W-1:0] req2_addr;
    logic [DATA_W-1:0] req2_data;
    logic              req2_ready;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              busy;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  req2_valid, req2_addr, req2_data,
        output req0_ready, req1_ready, req2_ready,
        output rf_we, rf_addr, rf_wdata, busy
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output req2_valid, req2_addr, req2_data,
        input  req0_ready, req1_ready, req2_ready,
        input  rf_we, rf_addr, rf_wdata, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among ALU, load and debug/CSR writeback.
// Define RF_CLEAR_ON_RESET_EN to compile in the post-reset sweep that zeroes x1..x(NUM_REGS-1).
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);

    if (NUM_REGS > (1 << ADDR_W) || NUM_REGS < 2) begin : gBadNumRegs
        $error("regfile_wb_arbiter: NUM_REGS does not fit ADDR_W");
    end

`ifdef RF_CLEAR_ON_RESET_EN
    typedef enum logic [0:0] {CLEAR, RUN} state_e;
    localparam state_e RESET_STATE = CLEAR;
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
`else
    typedef enum logic [0:0] {RUN} state_e;
    localparam state_e RESET_STATE = RUN;
`endif

    state_e            state_q;
    logic [1:0]        ptr_q;
    logic [1:0]        ptr_d;
    logic              rfWe_q;
    logic [ADDR_W-1:0] rfAddr_q;
    logic [DATA_W-1:0] rfWdata_q;
`ifdef RF_CLEAR_ON_RESET_EN
    logic [ADDR_W-1:0] sweepCnt_q;
    logic              sweeping;
`endif

    logic [2:0]        valid;
    logic [2:0]        grant;
    logic [2:0]        cand;
    logic [1:0]        grantIdx;
    logic              grantAny;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

    // Search ptr, ptr+1, ptr+2 (mod 3); readies are suppressed during reset and the sweep.
    always_comb begin
        valid    = {bus.req2_valid, bus.req1_valid, bus.req0_valid};
        grant    = 3'b000;
        grantIdx = 2'd0;
        grantAny = 1'b0;
        cand     = 3'd0;
        if (!rst && state_q == RUN) begin
            for (int k = 0; k < 3; k++) begin
                cand = {1'b0, ptr_q} + 3'(k);
                if (cand >= 3'd3) begin
                    cand = cand - 3'd3;
                end
                if (!grantAny && valid[cand[1:0]]) begin
                    grantAny = 1'b1;
                    grantIdx = cand[1:0];
                end
            end
            if (grantAny) begin
                grant[grantIdx] = 1'b1;
            end
        end

        case (grantIdx)
            2'd1: begin
                selAddr = bus.req1_addr;
                selData = bus.req1_data;
            end
            2'd2: begin
                selAddr = bus.req2_addr;
                selData = bus.req2_data;
            end
            default: begin
                selAddr = bus.req0_addr;
                selData = bus.req0_data;
            end
        endcase

        ptr_d = ptr_q;
        if (grantAny) begin
            ptr_d = (grantIdx == 2'd2) ? 2'd0 : grantIdx + 2'd1;
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.req2_ready = grant[2];

`ifdef RF_CLEAR_ON_RESET_EN
    // Sweep writes are driven in the cycle the counter holds them, so busy drops right after x31.
    assign sweeping     = !rst && state_q == CLEAR;
    assign bus.busy     = rst || state_q == CLEAR;
    assign bus.rf_we    = sweeping ? 1'b1 : rfWe_q;
    assign bus.rf_addr  = sweeping ? sweepCnt_q : rfAddr_q;
    assign bus.rf_wdata = sweeping ? {DATA_W{1'b0}} : rfWdata_q;
`else
    assign bus.busy     = 1'b0;
    assign bus.rf_we    = rfWe_q;
    assign bus.rf_addr  = rfAddr_q;
    assign bus.rf_wdata = rfWdata_q;
`endif

    // Accepted writes appear on the port one cycle later; writes to x0 are granted but dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            ptr_q     <= 2'd0;
            rfWe_q    <= 1'b0;
            rfAddr_q  <= '0;
            rfWdata_q <= '0;
`ifdef RF_CLEAR_ON_RESET_EN
            sweepCnt_q <= ADDR_W'(1);
`endif
        end else begin
            rfWe_q <= 1'b0;
            case (state_q)
`ifdef RF_CLEAR_ON_RESET_EN
                CLEAR: begin
                    rfAddr_q   <= sweepCnt_q;
                    rfWdata_q  <= '0;
                    sweepCnt_q <= sweepCnt_q + 1'b1;
                    if (sweepCnt_q == LAST_REG) begin
                        state_q <= RUN;
                    end
                end
`endif
                RUN: begin
                    ptr_q <= ptr_d;
                    if (grantAny && selAddr != '0) begin
                        rfWe_q    <= 1'b1;
                        rfAddr_q  <= selAddr;
                        rfWdata_q <= selData;
                    end
                end
                default: state_q <= RESET_STATE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin / writeback model.
module tb_regfile_wb_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [2:0]        tv;
    logic [ADDR_W-1:0] ta [3];
    logic [DATA_W-1:0] td [3];

    assign bus.req0_valid = tv[0];
    assign bus.req0_addr  = ta[0];
    assign bus.req0_data  = td[0];
    assign bus.req1_valid = tv[1];
    assign bus.req1_addr  = ta[1];
    assign bus.req1_data  = td[1];
    assign bus.req2_valid = tv[2];
    assign bus.req2_addr  = ta[2];
    assign bus.req2_data  = td[2];

    wire [2:0]             dutReady = {bus.req2_ready, bus.req1_ready, bus.req0_ready};
    wire [ADDR_W+DATA_W:0] dutRf    = {bus.rf_we, bus.rf_addr, bus.rf_wdata};

    // Reference model: rotating priority pointer and the write expected on the port.
    int                mPtr;
    logic              mWe;
    logic [ADDR_W-1:0] mAddr;
    logic [DATA_W-1:0] mData;

    int checkCount = 0;
    int passCount  = 0;

    function automatic int modelGrant(input logic [2:0] v, input int p);
        for (int k = 0; k < 3; k++) begin
            if (v[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [2:0] oneHot(input int g);
        return (g < 0) ? 3'b000 : 3'(1 << g);
    endfunction

    task automatic modelClock();
        int g;
        g   = modelGrant(tv, mPtr);
        mWe = 1'b0;
        if (g >= 0) begin
            mPtr = (g + 1) % 3;
            if (ta[g] != '0) begin
                mWe   = 1'b1;
                mAddr = ta[g];
                mData = td[g];
            end
        end
    endtask

    task automatic modelReset();
        mPtr  = 0;
        mWe   = 1'b0;
        mAddr = '0;
        mData = '0;
    endtask

    task automatic applyStimulus(input logic [2:0] v,
                                 input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                                 input logic [ADDR_W-1:0] a2,
                                 input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                                 input logic [DATA_W-1:0] d2);
        tv    = v;
        ta[0] = a0;
        ta[1] = a1;
        ta[2] = a2;
        td[0] = d0;
        td[1] = d1;
        td[2] = d2;
    endtask

    // Full reset, then (if compiled in) let the sweep run out with no requests pending.
    task automatic resetDut();
        tv  = 3'b000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
`ifdef RF_CLEAR_ON_RESET_EN
        repeat (NUM_REGS - 1) @(posedge clk);
        #1;
        mAddr = ADDR_W'(NUM_REGS - 1);
        mData = '0;
`endif
    endtask

    task automatic test_reset();
        logic expBusy;
`ifdef RF_CLEAR_ON_RESET_EN
        expBusy = 1'b1;
`else
        expBusy = 1'b0;
`endif
        applyStimulus(3'b001, 5'd9, 5'd0, 5'd0, $urandom, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (dutReady !== 3'b000)
            $display("[TB] FAIL reset_ready: got %b expected %b", dutReady, 3'b000);
        else passCount++;
        checkCount++;
        if (dutRf !== '0)
            $display("[TB] FAIL reset_rf: got %h expected %h", dutRf, {(ADDR_W+DATA_W+1){1'b0}});
        else passCount++;
        checkCount++;
        if (bus.busy !== expBusy)
            $display("[TB] FAIL reset_busy: got %b expected %b", bus.busy, expBusy);
        else passCount++;
        modelReset();
    endtask

`ifdef RF_CLEAR_ON_RESET_EN
    task automatic test_sweep();
        rst = 1'b0;
        for (int k = 1; k < NUM_REGS; k++) begin
            @(negedge clk);
            checkCount++;
            if (dutRf !== {1'b1, ADDR_W'(k), {DATA_W{1'b0}}})
                $display("[TB] FAIL sweep_rf[%0d]: got %h expected %h", k, dutRf,
                         {1'b1, ADDR_W'(k), {DATA_W{1'b0}}});
            else passCount++;
            checkCount++;
            if ({bus.busy, dutReady} !== 4'b1000)
                $display("[TB] FAIL sweep_busy_ready[%0d]: got %b expected %b", k,
                         {bus.busy, dutReady}, 4'b1000);
            else passCount++;
            @(posedge clk);
            #1;
        end
        mAddr = ADDR_W'(NUM_REGS - 1);
        mData = '0;
        @(negedge clk);
        checkCount++;
        if ({bus.busy, dutReady} !== 4'b0001)
            $display("[TB] FAIL sweep_first_grant: got %b expected %b", {bus.busy, dutReady}, 4'b0001);
        else passCount++;
        @(posedge clk);
        modelClock();
        #1;
        checkCount++;
        if (dutRf !== {mWe, mAddr, mData})
            $display("[TB] FAIL sweep_first_write: got %h expected %h", dutRf, {mWe, mAddr, mData});
        else passCount++;
        tv = 3'b000;
    endtask

    task automatic test_reset_mid_sweep();
        tv  = 3'b000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkCount++;
        if (dutRf !== {1'b1, 5'd10, {DATA_W{1'b0}}})
            $display("[TB] FAIL midsweep_at10: got %h expected %h", dutRf, {1'b1, 5'd10, {DATA_W{1'b0}}});
        else passCount++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkCount++;
        if (dutRf !== '0)
            $display("[TB] FAIL midsweep_reset_rf: got %h expected %h", dutRf, {(ADDR_W+DATA_W+1){1'b0}});
        else passCount++;
        rst = 1'b0;
        for (int k = 1; k < NUM_REGS; k++) begin
            @(negedge clk);
            checkCount++;
            if ({bus.busy, dutRf} !== {1'b1, 1'b1, ADDR_W'(k), {DATA_W{1'b0}}})
                $display("[TB] FAIL midsweep_restart[%0d]: got %h expected %h", k, {bus.busy, dutRf},
                         {1'b1, 1'b1, ADDR_W'(k), {DATA_W{1'b0}}});
            else passCount++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkCount++;
        if ({bus.busy, bus.rf_we} !== 2'b00)
            $display("[TB] FAIL midsweep_done: got %b expected %b", {bus.busy, bus.rf_we}, 2'b00);
        else passCount++;
        @(posedge clk);
        #1;
        mAddr = ADDR_W'(NUM_REGS - 1);
        mData = '0;
    endtask
`else
    task automatic test_no_clear();
        rst = 1'b0;
        @(negedge clk);
        checkCount++;
        if ({bus.busy, dutReady} !== 4'b0001)
            $display("[TB] FAIL noclear_first_grant: got %b expected %b", {bus.busy, dutReady}, 4'b0001);
        else passCount++;
        @(posedge clk);
        modelClock();
        #1;
        checkCount++;
        if (dutRf !== {1'b1, ta[0], td[0]})
            $display("[TB] FAIL noclear_first_write: got %h expected %h", dutRf, {1'b1, ta[0], td[0]});
        else passCount++;
        tv = 3'b000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkCount++;
            if ({bus.busy, dutReady} !== 4'b0000)
                $display("[TB] FAIL noclear_idle[%0d]: got %b expected %b", k, {bus.busy, dutReady}, 4'b0000);
            else passCount++;
            @(posedge clk);
            modelClock();
            #1;
        end
    endtask
`endif

    task automatic test_single_write();
        applyStimulus(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0);
        @(negedge clk);
        checkCount++;
        if (dutReady !== 3'b010)
            $display("[TB] FAIL single_ready: got %b expected %b", dutReady, 3'b010);
        else passCount++;
        @(posedge clk);
        modelClock();
        #1;
        checkCount++;
        if (dutRf !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("[TB] FAIL single_write: got %h expected %h", dutRf, {1'b1, 5'd5, 32'hDEADBEEF});
        else passCount++;
        tv = 3'b000;
        @(posedge clk);
        modelClock();
        #1;
        checkCount++;
        if (dutRf !== {1'b0, 5'd5, 32'hDEADBEEF})
            $display("[TB] FAIL single_after: got %h expected %h", dutRf, {1'b0, 5'd5, 32'hDEADBEEF});
        else passCount++;
    endtask

    task automatic test_round_robin();
        resetDut();
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkCount++;
            if (dutReady !== 3'(1 << (k % 3)))
                $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", k, dutReady, 3'(1 << (k % 3)));
            else passCount++;
            @(posedge clk);
            modelClock();
            #1;
            checkCount++;
            if (dutRf !== {1'b1, ADDR_W'(k % 3 + 1), DATA_W'(32'h11 * (k % 3 + 1))})
                $display("[TB] FAIL rr_write[%0d]: got %h expected %h", k, dutRf,
                         {1'b1, ADDR_W'(k % 3 + 1), DATA_W'(32'h11 * (k % 3 + 1))});
            else passCount++;
        end
        tv = 3'b000;
    endtask

    task automatic test_x0_drop();
        applyStimulus(3'b001, 5'd4, 5'd0, 5'd0, 32'h44, 32'h0, 32'h0);
        @(negedge clk);
        checkCount++;
        if (dutReady !== 3'b001)
            $display("[TB] FAIL x0_setup_ready: got %b expected %b", dutReady, 3'b001);
        else passCount++;
        @(posedge clk);
        modelClock();
        #1;
        applyStimulus(3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF);
        @(negedge clk);
        checkCount++;
        if (dutReady !== 3'b100)
            $display("[TB] FAIL x0_ready: got %b expected %b", dutReady, 3'b100);
        else passCount++;
        @(posedge clk);
        modelClock();
        #1;
        checkCount++;
        if (dutRf !== {1'b0, 5'd4, 32'h44})
            $display("[TB] FAIL x0_dropped: got %h expected %h", dutRf, {1'b0, 5'd4, 32'h44});
        else passCount++;
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
        @(negedge clk);
        checkCount++;
        if (dutReady !== 3'b001)
            $display("[TB] FAIL x0_ptr_advanced: got %b expected %b", dutReady, 3'b001);
        else passCount++;
        @(posedge clk);
        modelClock();
        #1;
        tv = 3'b000;
    endtask

    task automatic test_random();
        logic [2:0] granted;
        int         g;
        granted = 3'b000;
        tv      = 3'b000;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!tv[i] || granted[i]) begin
                    tv[i] = 1'($urandom_range(0, 1));
                    ta[i] = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
                    td[i] = $urandom;
                end
            end
            @(negedge clk);
            g = modelGrant(tv, mPtr);
            checkCount++;
            if (dutReady !== oneHot(g))
                $display("[TB] FAIL random_ready[%0d]: got %b expected %b", c, dutReady, oneHot(g));
            else passCount++;
            @(posedge clk);
            modelClock();
            #1;
            checkCount++;
            if (dutRf !== {mWe, mAddr, mData})
                $display("[TB] FAIL random_write[%0d]: got %h expected %h", c, dutRf, {mWe, mAddr, mData});
            else passCount++;
            granted = oneHot(g);
        end
        tv = 3'b000;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        modelReset();
        @(posedge clk);
        #1;
        test_reset();
`ifdef RF_CLEAR_ON_RESET_EN
        test_sweep();
`else
        test_no_clear();
`endif
        test_single_write();
        test_round_robin();
        test_x0_drop();
`ifdef RF_CLEAR_ON_RESET_EN
        test_reset_mid_sweep();
`endif
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
